matmul_engine: RTL and testbench

Parametrised, self-sequencing matrix-multiply engine. It computes C = A x B for an X-by-Y matrix A and a Y-by-Z matrix B, both stored row-major in a shared single-port data memory. It replaces the microcoded X/Y/Z loop registers, address registers and 24-bit accumulator path of the current processor with a hardware FSM. Data width, accumulator width, address width and overflow mode are configurable.

---
 rtl/mm_pkg.sv | 13 +
 rtl/mm_mac_unit.sv | 46 ++++
 rtl/matmul_engine.sv | 180 ++++++++++++++++++
 tb/tb_matmul_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply engine: FSM state encoding.
package mm_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    MAC   = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;
endpackage

// File: rtl/mm_mac_unit.sv
// Multiply-accumulate datapath: unsigned product, ACC_W-bit accumulator, wrap or clamp on overflow.
module mm_mac_unit
  import mm_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int SATURATE = 0
) (
  input  logic              clock,
  input  logic              rst_r,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] a_op,
  input  logic [DATA_W-1:0] b_op,
  output logic [ACC_W-1:0]  acc,
  output logic              sum_carry
);

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    acc_d, acc_q;

  always_comb begin
    prod      = (2*DATA_W)'(a_op) * (2*DATA_W)'(b_op);
    sum       = {1'b0, acc_q} + (ACC_W+1)'(prod);
    sum_carry = sum[ACC_W];
    acc_d     = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      // once clamped, any further nonzero product overflows again and re-clamps
      if (sum[ACC_W] && (SATURATE != 0)) acc_d = ACC_MAX;
      else                               acc_d = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge rst_r) begin
    if (rst_r) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_engine.sv
// Self-sequencing C = A x B engine over a shared single-port memory; row-major operands and results.
//
// state | meaning
// IDLE  | waiting for start; job parameters latched on accept
// RD_A  | read request for A[i][j]
// RD_B  | read request for B[j][k]; A operand captured
// MAC   | B operand arrives, accumulate, advance j and pointers
// WRITE | present C[i][k] until consumer accepts
// DONE  | one-cycle done pulse
module matmul_engine
  import mm_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int ADDR_W   = 16,
  parameter int DIM_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic              clock,
  input  logic              rst_r,
  input  logic              start,
  input  logic [DIM_W-1:0]  x_dim,
  input  logic [DIM_W-1:0]  y_dim,
  input  logic [DIM_W-1:0]  z_dim,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  state_t              state_d, state_q;
  logic [DIM_W-1:0]    x_d, x_q, y_d, y_q, z_d, z_q;
  logic [DIM_W-1:0]    i_d, i_q, j_d, j_q, k_d, k_q;
  logic [ADDR_W-1:0]   a_row_d, a_row_q, a_ptr_d, a_ptr_q;
  logic [ADDR_W-1:0]   b_base_d, b_base_q, b_col_d, b_col_q, b_ptr_d, b_ptr_q;
  logic [ADDR_W-1:0]   c_ptr_d, c_ptr_q;
  logic [DATA_W-1:0]   a_op_d, a_op_q;
  logic                ovf_d, ovf_q;
  logic                mem_req_d, mem_req_q, res_valid_d, res_valid_q;
  logic                busy_d, busy_q, done_d, done_q;
  logic [ADDR_W-1:0]   mem_addr_d, mem_addr_q;
  logic                mac_clear, mac_en, sum_carry;
  logic [ACC_W-1:0]    acc;

  mm_mac_unit #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_mac (
    .clock     (clock),
    .rst_r     (rst_r),
    .clear     (mac_clear),
    .enable    (mac_en),
    .a_op      (a_op_q),
    .b_op      (mem_rdata),
    .acc       (acc),
    .sum_carry (sum_carry)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;      y_d     = y_q;      z_d     = z_q;
    i_d      = i_q;      j_d     = j_q;      k_d     = k_q;
    a_row_d  = a_row_q;  a_ptr_d = a_ptr_q;
    b_base_d = b_base_q; b_col_d = b_col_q;  b_ptr_d = b_ptr_q;
    c_ptr_d  = c_ptr_q;
    a_op_d   = a_op_q;
    ovf_d    = ovf_q;
    mac_clear = 1'b0;
    mac_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d = x_dim; y_d = y_dim; z_d = z_dim;
          i_d = '0; j_d = '0; k_d = '0;
          a_row_d = a_base; a_ptr_d = a_base;
          b_base_d = b_base; b_col_d = b_base; b_ptr_d = b_base;
          c_ptr_d = c_base;
          ovf_d = 1'b0;
          mac_clear = 1'b1;
          if (x_dim == '0 || y_dim == '0 || z_dim == '0) state_d = DONE;
          else                                            state_d = RD_A;
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        a_op_d  = mem_rdata;
        state_d = MAC;
      end
      MAC: begin
        mac_en  = 1'b1;
        if (sum_carry) ovf_d = 1'b1;
        a_ptr_d = a_ptr_q + ADDR_W'(1);
        b_ptr_d = b_ptr_q + ADDR_W'(z_q);
        j_d     = j_q + DIM_W'(1);
        state_d = (j_q == y_q - DIM_W'(1)) ? WRITE : RD_A;
      end
      WRITE: begin
        if (res_ready) begin
          mac_clear = 1'b1;
          j_d       = '0;
          c_ptr_d   = c_ptr_q + ADDR_W'(1);
          if (k_q != z_q - DIM_W'(1)) begin
            k_d     = k_q + DIM_W'(1);
            a_ptr_d = a_row_q;
            b_col_d = b_col_q + ADDR_W'(1);
            b_ptr_d = b_col_q + ADDR_W'(1);
            state_d = RD_A;
          end else begin
            k_d     = '0;
            i_d     = i_q + DIM_W'(1);
            a_row_d = a_row_q + ADDR_W'(y_q);
            a_ptr_d = a_row_q + ADDR_W'(y_q);
            b_col_d = b_base_q;
            b_ptr_d = b_base_q;
            state_d = (i_q == x_q - DIM_W'(1)) ? DONE : RD_A;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // outputs are registered, decoded from the state being entered
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    res_valid_d = (state_d == WRITE);
    mem_req_d   = (state_d == RD_A) || (state_d == RD_B);
    mem_addr_d  = (state_d == RD_A) ? a_ptr_d :
                  (state_d == RD_B) ? b_ptr_d : '0;
  end

  always_ff @(posedge clock or posedge rst_r) begin
    if (rst_r) begin
      state_q  <= IDLE;
      x_q      <= '0; y_q <= '0; z_q <= '0;
      i_q      <= '0; j_q <= '0; k_q <= '0;
      a_row_q  <= '0; a_ptr_q <= '0;
      b_base_q <= '0; b_col_q <= '0; b_ptr_q <= '0;
      c_ptr_q  <= '0;
      a_op_q   <= '0;
      ovf_q    <= 1'b0;
      mem_req_q <= 1'b0; mem_addr_q <= '0;
      res_valid_q <= 1'b0;
      busy_q   <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d; y_q <= y_d; z_q <= z_d;
      i_q      <= i_d; j_q <= j_d; k_q <= k_d;
      a_row_q  <= a_row_d; a_ptr_q <= a_ptr_d;
      b_base_q <= b_base_d; b_col_q <= b_col_d; b_ptr_q <= b_ptr_d;
      c_ptr_q  <= c_ptr_d;
      a_op_q   <= a_op_d;
      ovf_q    <= ovf_d;
      mem_req_q <= mem_req_d; mem_addr_q <= mem_addr_d;
      res_valid_q <= res_valid_d;
      busy_q   <= busy_d; done_q <= done_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign res_valid = res_valid_q;
  assign res_addr  = c_ptr_q;
  assign res_data  = acc;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench for matmul_engine: directed jobs, stall, ignored restart, mid-job reset, overflow modes.
module tb_matmul_engine;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_r, start, start_sat, res_ready;
  logic [7:0]  x_dim, y_dim, z_dim;
  logic [15:0] a_base, b_base, c_base;

  logic        mem_req, res_valid, busy, done, ovf;
  logic [15:0] mem_addr, res_addr;
  logic [7:0]  mem_rdata = '0;
  logic [23:0] res_data;

  logic        s_mem_req, s_res_valid, s_busy, s_done, s_ovf;
  logic [15:0] s_mem_addr, s_res_addr, s_res_data;
  logic [7:0]  s_rdata = '0;
  logic        w_mem_req, w_res_valid, w_busy, w_done, w_ovf;
  logic [15:0] w_mem_addr, w_res_addr, w_res_data;
  logic [7:0]  w_rdata = '0;

  matmul_engine dut (
    .clock(clock), .rst_r(rst_r), .start(start),
    .x_dim(x_dim), .y_dim(y_dim), .z_dim(z_dim),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done), .ovf(ovf));

  matmul_engine #(.ACC_W(16), .SATURATE(1)) dut_sat (
    .clock(clock), .rst_r(rst_r), .start(start_sat),
    .x_dim(x_dim), .y_dim(y_dim), .z_dim(z_dim),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_rdata(s_rdata),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_addr(s_res_addr), .res_data(s_res_data),
    .busy(s_busy), .done(s_done), .ovf(s_ovf));

  matmul_engine #(.ACC_W(16), .SATURATE(0)) dut_wrap (
    .clock(clock), .rst_r(rst_r), .start(start_sat),
    .x_dim(x_dim), .y_dim(y_dim), .z_dim(z_dim),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_rdata(w_rdata),
    .res_valid(w_res_valid), .res_ready(res_ready), .res_addr(w_res_addr), .res_data(w_res_data),
    .busy(w_busy), .done(w_done), .ovf(w_ovf));

  logic [7:0] mem [0:65535];
  always @(posedge clock) begin
    if (mem_req)   mem_rdata <= mem[mem_addr];
    if (s_mem_req) s_rdata   <= mem[s_mem_addr];
    if (w_mem_req) w_rdata   <= mem[w_mem_addr];
  end

  int errors = 0;
  int checks = 0;
  int mreq_cnt = 0;
  int rv_cnt = 0;
  logic [39:0] q_main[$];
  logic [31:0] q_s[$];
  logic [31:0] q_w[$];
  logic [39:0] e_main;
  logic [31:0] e_s, e_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got result 0x%0h expected none", name, act);
  endtask

  // monitors sample a little after the falling edge, after stimulus has settled
  always @(negedge clock) begin
    #2;
    if (mem_req)   mreq_cnt++;
    if (res_valid) rv_cnt++;
    if (!rst_r && res_valid && res_ready) begin
      if (q_main.size() == 0) unexpected("main_extra_result", {res_addr, res_data});
      else begin
        e_main = q_main.pop_front();
        check("main_res_addr", res_addr, e_main[39:24]);
        check("main_res_data", res_data, e_main[23:0]);
      end
    end
    if (!rst_r && s_res_valid && res_ready) begin
      if (q_s.size() == 0) unexpected("sat_extra_result", {s_res_addr, s_res_data});
      else begin
        e_s = q_s.pop_front();
        check("sat_res_addr", s_res_addr, e_s[31:16]);
        check("sat_res_data", s_res_data, e_s[15:0]);
      end
    end
    if (!rst_r && w_res_valid && res_ready) begin
      if (q_w.size() == 0) unexpected("wrap_extra_result", {w_res_addr, w_res_data});
      else begin
        e_w = q_w.pop_front();
        check("wrap_res_addr", w_res_addr, e_w[31:16]);
        check("wrap_res_data", w_res_data, e_w[15:0]);
      end
    end
  end

  task automatic set_2x2();
    x_dim = 8'd2; y_dim = 8'd2; z_dim = 8'd2;
    a_base = 16'h0000; b_base = 16'h0010; c_base = 16'h0100;
  endtask

  task automatic push_2x2();
    q_main.push_back({16'h0100, 24'd19});
    q_main.push_back({16'h0101, 24'd22});
    q_main.push_back({16'h0102, 24'd43});
    q_main.push_back({16'h0103, 24'd50});
  endtask

  // lat = number of rising edges from the one sampling start to the one raising done
  task automatic run_main(output int lat);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      @(negedge clock);
      lat++;
    end
    if (!done) unexpected("main_done_timeout", 64'(lat));
  endtask

  int lat, n;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0000] = 8'd1; mem[16'h0001] = 8'd2; mem[16'h0002] = 8'd3; mem[16'h0003] = 8'd4;
    mem[16'h0010] = 8'd5; mem[16'h0011] = 8'd6; mem[16'h0012] = 8'd7; mem[16'h0013] = 8'd8;
    for (int a = 0; a < 3; a++) begin
      mem[16'h0200 + a] = 8'd255;
      mem[16'h0300 + a] = 8'd255;
    end

    rst_r = 1'b1; start = 1'b0; start_sat = 1'b0; res_ready = 1'b1;
    set_2x2();
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_res_data", res_data, 0);
    rst_r = 1'b0;
    @(negedge clock);

    // basic 2x2x2
    push_2x2();
    run_main(lat);
    check("basic_latency", lat, 29);
    check("basic_ovf", ovf, 0);
    @(negedge clock);
    check("basic_idle", busy, 0);

    // zero inner dimension
    y_dim = 8'd0;
    mreq_cnt = 0; rv_cnt = 0;
    run_main(lat);
    check("zero_latency", lat, 1);
    repeat (3) @(negedge clock);
    check("zero_mem_req_count", mreq_cnt, 0);
    check("zero_res_valid_count", rv_cnt, 0);
    set_2x2();

    // stall first result for 5 cycles
    res_ready = 1'b0;
    push_2x2();
    fork
      run_main(lat);
      begin
        n = 0;
        while (!res_valid && n < 100) begin
          @(negedge clock);
          n++;
        end
        for (int c = 0; c < 5; c++) begin
          check("stall_valid", res_valid, 1);
          check("stall_addr", res_addr, 16'h0100);
          check("stall_data", res_data, 24'd19);
          check("stall_no_mem_req", mem_req, 0);
          @(negedge clock);
        end
        res_ready = 1'b1;
      end
    join
    check("stall_latency", lat, 34);

    // restart attempt mid-job must be ignored
    @(negedge clock);
    push_2x2();
    fork
      run_main(lat);
      begin
        repeat (9) @(negedge clock);
        x_dim = 8'd3; y_dim = 8'd1; z_dim = 8'd1; c_base = 16'h0200;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
    join
    check("restart_latency", lat, 29);
    set_2x2();
    @(negedge clock);

    // reset while in MAC, then a fresh job
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    rst_r = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_mem_req", mem_req, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_addr", res_addr, 0);
    check("midrst_res_data", res_data, 0);
    check("midrst_done", done, 0);
    @(negedge clock);
    rst_r = 1'b0;
    @(negedge clock);
    push_2x2();
    run_main(lat);
    check("after_rst_latency", lat, 29);

    // overflow: 1x3x1 of 255s at 16-bit accumulator
    @(negedge clock);
    x_dim = 8'd1; y_dim = 8'd3; z_dim = 8'd1;
    a_base = 16'h0200; b_base = 16'h0300; c_base = 16'h0400;
    q_s.push_back({16'h0400, 16'hFFFF});
    q_w.push_back({16'h0400, 16'((3 * 65025) % 65536)});
    start_sat = 1'b1;
    @(negedge clock);
    start_sat = 1'b0;
    n = 1;
    while (!(s_done && w_done) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("ovf_latency", n, 11);
    check("sat_ovf", s_ovf, 1);
    check("wrap_ovf", w_ovf, 1);

    repeat (3) @(negedge clock);
    check("main_queue_drained", q_main.size(), 0);
    check("sat_queue_drained", q_s.size(), 0);
    check("wrap_queue_drained", q_w.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
